mp3_alias_reduction: RTL

Alias-reduction stage of the MP3 granule pipeline. It sits downstream of the `cs`/`ca` coefficient ROMs and between requantisation/reordering and the IMDCT. The block walks the 31 subband boundaries of one 576-sample granule held in the shared granule RAM. At each boundary it applies the 8 standard butterflies in place, using one single-port RAM access per cycle.

---
 rtl/mp3_alias_reduction_pkg.sv | 46 ++++
 rtl/mp3_alias_reduction_butterfly.sv | 32 +++
 rtl/mp3_alias_reduction.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mp3_alias_reduction_pkg.sv
// Shared widths, constants, FSM encoding and the output saturation helper
// for the MP3 alias-reduction stage.
package mp3_alias_reduction_pkg;

  localparam int SAMPLE_W       = 18;
  localparam int COEF_W         = 18;
  localparam int COEF_FRAC      = 17;
  localparam int GRANULE_LEN    = 576;
  localparam int SUBBAND_LEN    = 18;
  localparam int NUM_BOUNDARIES = 31;
  localparam int ALIAS_TAPS     = 8;
  localparam int ADDR_W         = 10;
  localparam int SB_W           = 5;
  localparam int IDX_W          = 3;

  localparam int PROD_W = SAMPLE_W + COEF_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam int SHR_W  = SUM_W - COEF_FRAC;

  localparam logic [1:0] BLOCK_SHORT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_RD_B  = 3'd2,
    S_CAP_B = 3'd3,
    S_MUL   = 3'd4,
    S_WR_A  = 3'd5,
    S_WR_B  = 3'd6,
    S_FIN   = 3'd7
  } state_e;

  // Clamp the shifted sum into the signed sample range.
  function automatic logic signed [SAMPLE_W-1:0] sat_sample(input logic signed [SHR_W-1:0] v);
    logic signed [SAMPLE_W-1:0] r;
    if (v > 20'sh1FFFF) begin
      r = 18'sh1FFFF;
    end else if (v < 20'shE0000) begin
      r = 18'sh20000;
    end else begin
      r = v[SAMPLE_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/mp3_alias_reduction_butterfly.sv
// One butterfly output: x0*c0 -/+ x1*c1, arithmetic shift by the coefficient
// fraction width, then saturation.
module mp3_alias_reduction_butterfly
  import mp3_alias_reduction_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] x0_i,
  input  logic signed [COEF_W-1:0]   c0_i,
  input  logic signed [SAMPLE_W-1:0] x1_i,
  input  logic signed [COEF_W-1:0]   c1_i,
  input  logic                       sub_i,
  output logic signed [SAMPLE_W-1:0] y_o
);

  logic signed [PROD_W-1:0] p0_s;
  logic signed [PROD_W-1:0] p1_s;
  logic signed [SUM_W-1:0]  sum_s;

  assign p0_s = x0_i * c0_i;
  assign p1_s = x1_i * c1_i;

  always_comb begin
    if (sub_i) begin
      sum_s = SUM_W'(p0_s) - SUM_W'(p1_s);
    end else begin
      sum_s = SUM_W'(p0_s) + SUM_W'(p1_s);
    end
  end

  // Dropping the low fraction bits is the truncating arithmetic shift.
  assign y_o = sat_sample(sum_s[SUM_W-1:COEF_FRAC]);

endmodule

// File: rtl/mp3_alias_reduction.sv
// In-place alias-reduction butterflies over one granule, one single-port RAM
// access per cycle, six cycles per butterfly.
module mp3_alias_reduction
  import mp3_alias_reduction_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       start_i,
  input  logic [1:0]                 block_type_i,
  input  logic                       mixed_block_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic                       mem_rd_en_o,
  input  logic signed [SAMPLE_W-1:0] mem_rd_data_i,
  output logic                       mem_wr_en_o,
  output logic signed [SAMPLE_W-1:0] mem_wr_data_o,
  output logic                       coef_enable_o,
  output logic [IDX_W-1:0]           coef_index_o,
  input  logic signed [COEF_W-1:0]   cs_data_i,
  input  logic signed [COEF_W-1:0]   ca_data_i
);

  state_e state_q, state_d;
  logic [SB_W-1:0]  sb_q, sb_d, nb_q, nb_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic signed [SAMPLE_W-1:0] a_q, b_q, rb_q, ya_s, yb_s;
  logic signed [COEF_W-1:0]   cs_q, ca_q;

  logic                       busy_d, done_d, rd_en_d, wr_en_d, coef_en_d;
  logic [ADDR_W-1:0]          addr_d, base_s, addr_a_s, addr_b_s;
  logic signed [SAMPLE_W-1:0] wr_data_d;
  logic [IDX_W-1:0]           coef_idx_d;

  mp3_alias_reduction_butterfly u_bf_a (
    .x0_i(a_q), .c0_i(cs_q), .x1_i(b_q), .c1_i(ca_q), .sub_i(1'b1), .y_o(ya_s)
  );

  mp3_alias_reduction_butterfly u_bf_b (
    .x0_i(b_q), .c0_i(cs_q), .x1_i(a_q), .c1_i(ca_q), .sub_i(1'b0), .y_o(yb_s)
  );

  always_comb begin
    state_d = state_q;
    sb_d    = sb_q;
    idx_d   = idx_q;
    nb_d    = nb_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          sb_d  = 5'd1;
          idx_d = 3'd0;
          if (block_type_i != BLOCK_SHORT) begin
            nb_d = 5'(NUM_BOUNDARIES);
          end else if (mixed_block_i) begin
            nb_d = 5'd1;
          end else begin
            nb_d = 5'd0;
          end
          state_d = (nb_d == 5'd0) ? S_FIN : S_RD_A;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_A:  state_d = S_RD_B;
      S_RD_B:  state_d = S_CAP_B;
      S_CAP_B: state_d = S_MUL;
      S_MUL:   state_d = S_WR_A;
      S_WR_A:  state_d = S_WR_B;
      S_WR_B: begin
        if (idx_q != 3'(ALIAS_TAPS - 1)) begin
          idx_d   = idx_q + 3'd1;
          state_d = S_RD_A;
        end else if (sb_q != nb_q) begin
          idx_d   = 3'd0;
          sb_d    = sb_q + 5'd1;
          state_d = S_RD_A;
        end else begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        sb_d    = 5'd0;
        idx_d   = 3'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign base_s   = ADDR_W'(sb_d) * 10'(SUBBAND_LEN);
  assign addr_a_s = base_s - 10'd1 - ADDR_W'(idx_d);
  assign addr_b_s = base_s + ADDR_W'(idx_d);

  // Outputs are decoded from the next state so they can be registered
  // and still line up with the state they belong to.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = 1'b0;
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    coef_en_d  = 1'b0;
    coef_idx_d = 3'd0;
    addr_d     = 10'd0;
    wr_data_d  = 18'sd0;
    case (state_d)
      S_RD_A: begin
        rd_en_d    = 1'b1;
        addr_d     = addr_a_s;
        coef_en_d  = 1'b1;
        coef_idx_d = idx_d;
      end
      S_RD_B: begin
        rd_en_d = 1'b1;
        addr_d  = addr_b_s;
      end
      S_WR_A: begin
        wr_en_d   = 1'b1;
        addr_d    = addr_a_s;
        wr_data_d = ya_s;
      end
      S_WR_B: begin
        wr_en_d   = 1'b1;
        addr_d    = addr_b_s;
        wr_data_d = rb_q;
      end
      S_FIN:   done_d = 1'b1;
      default: done_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q       <= S_IDLE;
      sb_q          <= 5'd0;
      idx_q         <= 3'd0;
      nb_q          <= 5'd0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      mem_rd_en_o   <= 1'b0;
      mem_wr_en_o   <= 1'b0;
      mem_addr_o    <= 10'd0;
      mem_wr_data_o <= 18'sd0;
      coef_enable_o <= 1'b0;
      coef_index_o  <= 3'd0;
    end else begin
      state_q       <= state_d;
      sb_q          <= sb_d;
      idx_q         <= idx_d;
      nb_q          <= nb_d;
      busy_o        <= busy_d;
      done_o        <= done_d;
      mem_rd_en_o   <= rd_en_d;
      mem_wr_en_o   <= wr_en_d;
      mem_addr_o    <= addr_d;
      mem_wr_data_o <= wr_data_d;
      coef_enable_o <= coef_en_d;
      coef_index_o  <= coef_idx_d;
    end
  end

  // Read data and coefficients arrive one cycle after their strobe.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      a_q  <= 18'sd0;
      b_q  <= 18'sd0;
      cs_q <= 18'sd0;
      ca_q <= 18'sd0;
      rb_q <= 18'sd0;
    end else begin
      if (state_q == S_RD_B) begin
        a_q  <= mem_rd_data_i;
        cs_q <= cs_data_i;
        ca_q <= ca_data_i;
      end
      if (state_q == S_CAP_B) begin
        b_q <= mem_rd_data_i;
      end
      if (state_q == S_MUL) begin
        rb_q <= yb_s;
      end
    end
  end

endmodule
